conv_line_ram: RTL and testbench
================================

// Module: conv_line_ram
// PURPOSE
//  Parametrised single-clock sample buffer for the convolution datapath. Writes
//  append at an internal write pointer (no write address); reads are random-access
//  and registered, one-cycle latency, with a valid strobe. Adds occupancy count,
//  full flag, overflow policy (saturate or wrap), sync clear, read-during-write rule.
//  Feeds the multiplier/accumulator; sits between input loader and conv controller.
// PARAMETERS
//  N     8  data word width (bits)
//  M     4  address width; DEPTH = 2**M words
//  WRAP  0  0: writes when full are dropped and flagged; 1: pointer wraps, overwrite oldest
// PORTS
//  clk       in   1    clock, all state on rising edge
//  rst       in   1    asynchronous, active-low reset (0 = reset)
//  clr       in   1    sync clear: pointer and count to 0
//  wr        in   1    write strobe; datain stored at mem[top]
//  datain    in   N    write data
//  rd        in   1    read request, sampled on clk
//  adr       in   M    read address
//  dataout   out  N    registered read data
//  rd_valid  out  1    1-cycle pulse: dataout holds result of previous-cycle rd
//  count     out  M+1  words written since reset/clr, saturates at DEPTH
//  full      out  1    count == DEPTH
//  wr_err    out  1    1-cycle pulse: write dropped (WRAP=0 and full)
// BEHAVIOUR
//  - Reset (rst=0, async): top=0, count=0, full=0, dataout=0, rd_valid=0, wr_err=0.
//    Memory array is NOT reset; unwritten contents are X.
//  - Write: wr=1 and (!full or WRAP=1) -> mem[top]<=datain, top<=top+1 (mod DEPTH),
//    count<=min(count+1,DEPTH). WRAP=0, full, wr=1 -> no store, top/count hold, wr_err=1.
//  - WRAP=1: full stays 1 after first wrap until clr/rst; wr_err never asserts.
//  - Read: rd=1 at edge k -> dataout=mem[adr], rd_valid=1 after edge k.
//    rd=0 -> rd_valid=0, dataout holds. No bounds check on adr vs count.
//  - clr=1: top<=0, count<=0, full<=0; clr beats wr (same-cycle write dropped, no
//    wr_err). A read in the clr cycle still completes normally.
//  - Read-during-write, adr==top with accepted write: see CONFIGURATION.
//  - Reads and writes are independent; both may occur every cycle.
// CONFIGURATION
//  Macro CONV_RAM_RDW_BYPASS_EN:
//   defined   -> accepted write with rd=1 and adr==top: dataout=datain (new data).
//   undefined -> same case returns old mem[adr]. No other behaviour differs.
// STRUCTURE
//  - Package conv_ram_pkg: WRAP mode localparams (MODE_SAT=0, MODE_WRAP=1) and
//    function depth_of(M)=2**M; shared with the conv controller.
//  - Sub-module conv_ram_ptr: top, count, full, wr_err, accept logic (clr/wr/WRAP
//    priority). Top level keeps storage array and read register.
// TESTING (N=8, M=2, DEPTH=4)
//  1. rst pulse; write 0x11,0x22,0x33; rd adr=1 -> next cycle dataout=0x22,
//     rd_valid=1; count=3, full=0.
//  2. WRAP=0: write 0x11..0x44 then 0x55 -> wr_err pulses once, count=4, full=1;
//     rd adr=0 -> 0x11.
//  3. WRAP=1: same writes -> wr_err=0, count=4, full=1; rd adr=0 -> 0x55, adr=1 -> 0x22.
//  4. count=3; clr=1 with wr=1, datain=0x77 -> count=0, full=0, wr_err=0; next
//     write 0x88 lands at adr 0 (rd adr=0 -> 0x88).
//  5. top=2, mem[2]=0x33 from earlier pass; wr 0xAA + rd adr=2 same cycle -> dataout=0xAA
//     with CONV_RAM_RDW_BYPASS_EN, 0x33 without.
//  6. rd=1 in flight, drop rst mid-cycle -> dataout=0, rd_valid=0, count=0 at once,
//     no wait for clk.

Source files
------------

// File: rtl/conv_ram_pkg.sv
// Shared constants for the convolution line RAM and its controller:
// overflow policy encodings and the depth helper.
package conv_ram_pkg;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

  function automatic int depth_of(input int m);
    return 2 ** m;
  endfunction

endpackage

// File: rtl/conv_ram_ptr.sv
// Write-side bookkeeping for conv_line_ram: append pointer, occupancy,
// full flag, dropped-write pulse and the write-accept decision.
module conv_ram_ptr
  import conv_ram_pkg::*;
#(
  parameter int M    = 4,
  parameter int WRAP = MODE_SAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr,
  output logic [M-1:0] top,
  output logic [M:0]   count,
  output logic         full,
  output logic         wr_err,
  output logic         accept
);

  localparam logic [M:0] DEPTH_C = (M+1)'(depth_of(M));

  logic [M-1:0] r_top;
  logic [M:0]   r_count;
  logic         r_wr_err;
  logic         w_full;

  // Count saturates at DEPTH, so in wrap mode full stays set until clr/reset.
  assign w_full = (r_count == DEPTH_C);
  // Clear wins over write; a full buffer only takes writes in wrap mode.
  assign accept = wr && !clr && (!w_full || (WRAP == MODE_WRAP));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top    <= '0;
      r_count  <= '0;
      r_wr_err <= 1'b0;
    end else if (clr) begin
      r_top    <= '0;
      r_count  <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr && w_full && (WRAP == MODE_SAT);
      if (accept) begin
        r_top <= r_top + M'(1);
        if (!w_full) r_count <= r_count + (M+1)'(1);
      end
    end
  end

  assign top    = r_top;
  assign count  = r_count;
  assign full   = w_full;
  assign wr_err = r_wr_err;

endmodule

// File: rtl/conv_line_ram.sv
// Append-write, random-read sample buffer with registered one-cycle reads.
// Define CONV_RAM_RDW_BYPASS_EN to return the incoming word on a read of the slot being written.
module conv_line_ram
  import conv_ram_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int WRAP = MODE_SAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr,
  input  logic [N-1:0] datain,
  input  logic         rd,
  input  logic [M-1:0] adr,
  output logic [N-1:0] dataout,
  output logic         rd_valid,
  output logic [M:0]   count,
  output logic         full,
  output logic         wr_err
);

  localparam int DEPTH = depth_of(M);

  logic [N-1:0] r_mem [DEPTH];
  logic [N-1:0] r_dataout;
  logic         r_rd_valid;
  logic [M-1:0] w_top;
  logic         w_accept;
  logic [N-1:0] w_rd_data;

  conv_ram_ptr #(
    .M    (M),
    .WRAP (WRAP)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wr     (wr),
    .top    (w_top),
    .count  (count),
    .full   (full),
    .wr_err (wr_err),
    .accept (w_accept)
  );

  // NOTE: the storage array has no reset so it maps onto plain RAM; unwritten
  // words read back as X.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[w_top] <= datain;
  end

`ifdef CONV_RAM_RDW_BYPASS_EN
  assign w_rd_data = (w_accept && (adr == w_top)) ? datain : r_mem[adr];
`else
  assign w_rd_data = r_mem[adr];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dataout  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd;
      if (rd) r_dataout <= w_rd_data;
    end
  end

  assign dataout  = r_dataout;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_conv_line_ram.sv
// Directed bench for conv_line_ram: a saturating and a wrapping instance
// (N=8, M=2) driven in lockstep, checked with immediate assertions.
module tb_conv_line_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr;
  logic [7:0] datain;
  logic       rd;
  logic [1:0] adr;

  logic [7:0] s_dataout, w_dataout;
  logic       s_rd_valid, w_rd_valid;
  logic [2:0] s_count, w_count;
  logic       s_full, w_full;
  logic       s_wr_err, w_wr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_line_ram #(.N(8), .M(2), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .datain(datain), .rd(rd), .adr(adr),
    .dataout(s_dataout), .rd_valid(s_rd_valid), .count(s_count), .full(s_full),
    .wr_err(s_wr_err)
  );

  conv_line_ram #(.N(8), .M(2), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .datain(datain), .rd(rd), .adr(adr),
    .dataout(w_dataout), .rd_valid(w_rd_valid), .count(w_count), .full(w_full),
    .wr_err(w_wr_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr     = 1'b1;
    datain = d;
    step();
    wr     = 1'b0;
  endtask

  logic [7:0] rdw_exp;

  initial begin
    rst = 1'b0; clr = 1'b0; wr = 1'b0; datain = '0; rd = 1'b0; adr = '0;
    #12;
    check("rst_dataout", 16'(s_dataout), 16'h00);
    check("rst_rd_valid", 16'(s_rd_valid), 16'h0);
    check("rst_count", 16'(s_count), 16'h0);
    check("rst_full", 16'(s_full), 16'h0);
    check("rst_wr_err", 16'(s_wr_err), 16'h0);
    check("rst_wrap_count", 16'(w_count), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // 1: three writes then a read of address 1
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    rd = 1'b1; adr = 2'd1;
    step();
    rd = 1'b0;
    check("t1_dataout", 16'(s_dataout), 16'h22);
    check("t1_rd_valid", 16'(s_rd_valid), 16'h1);
    check("t1_count", 16'(s_count), 16'h3);
    check("t1_full", 16'(s_full), 16'h0);
    check("t1_wrap_dataout", 16'(w_dataout), 16'h22);
    step();
    check("t1_rd_valid_drop", 16'(s_rd_valid), 16'h0);
    check("t1_dataout_hold", 16'(s_dataout), 16'h22);

    // 2/3: fill, then one write past full
    write_word(8'h44);
    check("t2_full", 16'(s_full), 16'h1);
    check("t2_count", 16'(s_count), 16'h4);
    write_word(8'h55);
    check("t2_wr_err", 16'(s_wr_err), 16'h1);
    check("t2_count_hold", 16'(s_count), 16'h4);
    check("t2_full_hold", 16'(s_full), 16'h1);
    check("t3_wr_err", 16'(w_wr_err), 16'h0);
    check("t3_count", 16'(w_count), 16'h4);
    check("t3_full", 16'(w_full), 16'h1);
    rd = 1'b1; adr = 2'd0;
    step();
    check("t2_wr_err_pulse", 16'(s_wr_err), 16'h0);
    check("t2_rd0", 16'(s_dataout), 16'h11);
    check("t3_rd0", 16'(w_dataout), 16'h55);
    adr = 2'd1;
    step();
    rd = 1'b0;
    check("t2_rd1", 16'(s_dataout), 16'h22);
    check("t3_rd1", 16'(w_dataout), 16'h22);
    check("t3_full_sticky", 16'(w_full), 16'h1);

    // 4: clear beats a same-cycle write
    clr = 1'b1;
    step();
    clr = 1'b0;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    check("t4_pre_count", 16'(s_count), 16'h3);
    clr = 1'b1; wr = 1'b1; datain = 8'h77;
    step();
    clr = 1'b0; wr = 1'b0;
    check("t4_count", 16'(s_count), 16'h0);
    check("t4_full", 16'(s_full), 16'h0);
    check("t4_wr_err", 16'(s_wr_err), 16'h0);
    check("t4_wrap_count", 16'(w_count), 16'h0);
    write_word(8'h88);
    check("t4_count1", 16'(s_count), 16'h1);
    rd = 1'b1; adr = 2'd0;
    step();
    rd = 1'b0;
    check("t4_rd0", 16'(s_dataout), 16'h88);
    check("t4_wrap_rd0", 16'(w_dataout), 16'h88);

    // 5: read of the slot being written (mem[2] holds 0x33)
    write_word(8'h99);
`ifdef CONV_RAM_RDW_BYPASS_EN
    rdw_exp = 8'hAA;
`else
    rdw_exp = 8'h33;
`endif
    wr = 1'b1; datain = 8'hAA; rd = 1'b1; adr = 2'd2;
    step();
    wr = 1'b0;
    check("t5_rdw", 16'(s_dataout), 16'(rdw_exp));
    check("t5_wrap_rdw", 16'(w_dataout), 16'(rdw_exp));
    step();
    check("t5_rd2_after", 16'(s_dataout), 16'hAA);
    check("t5_count", 16'(s_count), 16'h3);

    // 6: asynchronous reset mid-cycle with a read in flight
    adr = 2'd0;
    step();
    check("t6_pre_dataout", 16'(s_dataout), 16'h88);
    check("t6_pre_rd_valid", 16'(s_rd_valid), 16'h1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_dataout", 16'(s_dataout), 16'h00);
    check("t6_rd_valid", 16'(s_rd_valid), 16'h0);
    check("t6_count", 16'(s_count), 16'h0);
    check("t6_wrap_count", 16'(w_count), 16'h0);
    check("t6_wrap_dataout", 16'(w_dataout), 16'h00);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
